te_block_serializer: RTL and testbench
======================================

TE_BLOCK_SERIALIZER -- requirements
Module: te_block_serializer

Interface
REQ-001 SHALL have parameter N, default 2: number of parallel block lanes produced per cycle by multiple_retirement.
REQ-002 SHALL have parameter DEPTH, default 8: FIFO entries; power of two, at least 2*N.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk_i  in  1  clock; all state changes on the rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 valid_i  in  N  per-lane block valid from multiple_retirement.
REQ-007 iretire_i, ilastsize_i, itype_i, cause_i, tval_i, priv_i, iaddr_i  in  N x (IRETIRE_LEN, 1, ITYPE_LEN, CAUSE_LEN, XLEN, PRIV_LEN, XLEN)  per-lane block fields.
REQ-008 ready_o  out  1  high when at least N entries are free.
REQ-009 valid_o  out  1  head entry is valid toward the trace encoder.
REQ-010 ready_i  in  1  trace encoder accepts the head entry.
REQ-011 iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o  out  single-block widths  head entry fields.
REQ-012 overflow_o  out  1  sticky: at least one block group was dropped.
REQ-013 dropped_cnt_o  out  16  saturating count of dropped blocks.

Function
REQ-014 SHALL store blocks in a circular FIFO with head pointer, tail pointer (log2(DEPTH) bits, modulo wrap) and count (log2(DEPTH)+1 bits).
REQ-015 SHALL compute ready_o combinationally as (DEPTH - count) >= N from registered count.
REQ-016 Push: when ready_o is high, SHALL write all set valid_i lanes, compacted in ascending lane order, to tail, tail+1, and so on; tail advances by popcount(valid_i).
REQ-017 Gaps SHALL be removed: for example, valid_i=2'b10 writes lane 1 into the tail slot.
REQ-018 Pop: when valid_o and ready_i are both high, head SHALL advance by 1.
REQ-019 valid_o SHALL equal (count != 0); output fields SHALL be driven directly from the head entry with no additional register.
REQ-020 Latency: a block pushed at edge k SHALL be visible on the outputs after edge k, with no bypass when the FIFO is empty.
REQ-021 Simultaneous push and pop: count SHALL update as count + popcount(valid_i) - pop in the same cycle.
REQ-022 ready_o SHALL use pre-pop count, so a pop does not create room in the same cycle.
REQ-023 Overflow: if any valid_i is set while ready_o is low, SHALL drop the entire group, set overflow_o, and add popcount(valid_i) to dropped_cnt_o, saturating at 16'hFFFF.
REQ-024 On overflow, SHALL leave the FIFO contents and pointers unchanged; a pop in the same cycle still proceeds.
REQ-025 Output fields with valid_o low SHALL hold the stale head-slot contents; the bench SHALL NOT check them.
REQ-026 Block ordering SHALL be preserved: lane order within a cycle, then cycle order.

Reset
REQ-027 On rst_i, SHALL asynchronously clear head, tail, count, overflow_o and dropped_cnt_o.
REQ-028 After reset, SHALL drive valid_o=0 and ready_o=1; storage contents need not be cleared.
REQ-029 Reset mid-operation SHALL discard all stored blocks; the first push after release is written to slot 0.

Structure
REQ-030 The block record typedef te_block_t (iretire, ilastsize, itype, cause, tval, priv, iaddr) SHALL reside in mure_pkg alongside the existing length constants.
REQ-031 Lane compaction SHALL be implemented in sub-module block_compactor (combinational; N lanes in, packed lanes plus count out).
REQ-032 FIFO storage SHALL be an array of te_block_t inside te_block_serializer.

Verification
REQ-033 Reset release, then valid_i=2'b11 (iaddr 0x100, 0x104) with ready_i=1 -> valid_o high for 2 cycles, iaddr_o 0x100 then 0x104.
REQ-034 valid_i=2'b10 (lane 1 iaddr 0x200) -> single entry, iaddr_o=0x200, count=1.
REQ-035 ready_i=0 with pairs pushed every cycle -> ready_o low after 4 pushes (count=8; DEPTH=8, N=2); next pair dropped, overflow_o=1, dropped_cnt_o=2, contents intact.
REQ-036 Continuous push of 2 blocks per cycle with ready_i=1 for 20 cycles -> head and tail wrap correctly, 40 blocks emitted in order, no duplicates.
REQ-037 Assert rst_i with count=5 mid-stream -> valid_o=0, ready_o=1, overflow_o=0 immediately; next pushed block appears first.
REQ-038 Force 70000 dropped blocks -> dropped_cnt_o saturates at 0xFFFF.

Source files
------------

// File: rtl/mure_pkg.sv
// Shared trace-encoder field widths and the block record carried from
// multiple_retirement to the trace encoder.
package mure_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned IRETIRE_LEN = 32;
    localparam int unsigned ITYPE_LEN   = 3;
    localparam int unsigned CAUSE_LEN   = 5;
    localparam int unsigned PRIV_LEN    = 2;

    typedef struct packed {
        logic [IRETIRE_LEN-1:0] iretire;
        logic                   ilastsize;
        logic [ITYPE_LEN-1:0]   itype;
        logic [CAUSE_LEN-1:0]   cause;
        logic [XLEN-1:0]        tval;
        logic [PRIV_LEN-1:0]    priv;
        logic [XLEN-1:0]        iaddr;
    } te_block_t;

    // 16-bit counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/block_compactor.sv
// Squeezes the valid lanes of a block group to the low slots, keeping lane
// order, and reports how many lanes were valid.
module block_compactor
    import mure_pkg::*;
#(
    parameter int unsigned N = 2,
    localparam int unsigned CntW = $clog2(N + 1)
) (
    input  logic      [N-1:0] valid,
    input  te_block_t [N-1:0] blk,
    output te_block_t [N-1:0] packed_blk,
    output logic [CntW-1:0]   count
);

    // Lane i lands in slot j when exactly j valid lanes precede it.
    always_comb begin
        int unsigned seen;
        seen       = 0;
        packed_blk = '0;
        for (int i = 0; i < N; i++) begin
            if (valid[i]) begin
                for (int j = 0; j < N; j++) begin
                    if (seen == j) begin
                        packed_blk[j] = blk[i];
                    end
                end
                seen = seen + 1;
            end
        end
        count = CntW'(seen);
    end

endmodule

// File: rtl/te_block_serializer.sv
// Accepts up to N retirement blocks per cycle and hands them to the trace
// encoder one per cycle through a circular FIFO. Groups that do not fit are
// dropped whole and tallied.
module te_block_serializer
    import mure_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [N-1:0]                    valid_i,
    input  logic [N-1:0][IRETIRE_LEN-1:0]   iretire_i,
    input  logic [N-1:0]                    ilastsize_i,
    input  logic [N-1:0][ITYPE_LEN-1:0]     itype_i,
    input  logic [N-1:0][CAUSE_LEN-1:0]     cause_i,
    input  logic [N-1:0][XLEN-1:0]          tval_i,
    input  logic [N-1:0][PRIV_LEN-1:0]      priv_i,
    input  logic [N-1:0][XLEN-1:0]          iaddr_i,
    output logic                            ready_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [IRETIRE_LEN-1:0]          iretire_o,
    output logic                            ilastsize_o,
    output logic [ITYPE_LEN-1:0]            itype_o,
    output logic [CAUSE_LEN-1:0]            cause_o,
    output logic [XLEN-1:0]                 tval_o,
    output logic [PRIV_LEN-1:0]             priv_o,
    output logic [XLEN-1:0]                 iaddr_o,
    output logic                            overflow_o,
    output logic [15:0]                     dropped_cnt_o
);

    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned LaneW = $clog2(N + 1);

    te_block_t [N-1:0] lane_blk;
    te_block_t [N-1:0] packed_blk;
    logic [LaneW-1:0]  push_cnt;

    te_block_t         mem_q [DEPTH];
    logic [PtrW-1:0]   head_q, head_d;
    logic [PtrW-1:0]   tail_q, tail_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       dropped_q, dropped_d;

    logic              any_valid;
    logic              push;
    logic              drop;
    logic              pop;

    // Gather the per-lane input fields into block records.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            lane_blk[i].iretire   = iretire_i[i];
            lane_blk[i].ilastsize = ilastsize_i[i];
            lane_blk[i].itype     = itype_i[i];
            lane_blk[i].cause     = cause_i[i];
            lane_blk[i].tval      = tval_i[i];
            lane_blk[i].priv      = priv_i[i];
            lane_blk[i].iaddr     = iaddr_i[i];
        end
    end

    block_compactor #(
        .N (N)
    ) u_compactor (
        .valid      (valid_i),
        .blk        (lane_blk),
        .packed_blk (packed_blk),
        .count      (push_cnt)
    );

    // Room is judged on the registered count only; a pop this cycle does not help.
    assign ready_o   = count_q <= CntW'(DEPTH - N);
    assign valid_o   = count_q != '0;
    assign any_valid = |valid_i;
    assign push      = ready_o && any_valid;
    assign drop      = !ready_o && any_valid;
    assign pop       = valid_o && ready_i;

    // Next-state for pointers, occupancy and drop bookkeeping.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        dropped_d  = dropped_q;
        if (push) begin
            tail_d  = tail_q + PtrW'(push_cnt);
            count_d = count_d + CntW'(push_cnt);
        end
        if (pop) begin
            head_d  = head_q + PtrW'(1);
            count_d = count_d - CntW'(1);
        end
        if (drop) begin
            overflow_d = 1'b1;
            dropped_d  = sat_add16(dropped_q, 16'(push_cnt));
        end
    end

    // Control state with asynchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
        end
    end

    // Storage write: compacted lanes go to consecutive slots from the tail.
    always_ff @(posedge clk_i) begin
        if (push) begin
            for (int i = 0; i < N; i++) begin
                if (LaneW'(i) < push_cnt) begin
                    mem_q[tail_q + PtrW'(i)] <= packed_blk[i];
                end
            end
        end
    end

    // Head slot drives the outputs directly; stale when valid_o is low.
    assign iretire_o     = mem_q[head_q].iretire;
    assign ilastsize_o   = mem_q[head_q].ilastsize;
    assign itype_o       = mem_q[head_q].itype;
    assign cause_o       = mem_q[head_q].cause;
    assign tval_o        = mem_q[head_q].tval;
    assign priv_o        = mem_q[head_q].priv;
    assign iaddr_o       = mem_q[head_q].iaddr;
    assign overflow_o    = overflow_q;
    assign dropped_cnt_o = dropped_q;

endmodule

// File: tb/tb_te_block_serializer.sv
// Directed bench for te_block_serializer with N=2, DEPTH=8.
module tb_te_block_serializer;
    import mure_pkg::*;

    localparam int unsigned N     = 2;
    localparam int unsigned DEPTH = 8;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic [N-1:0]                  valid_i = '0;
    logic [N-1:0][IRETIRE_LEN-1:0] iretire_i = '0;
    logic [N-1:0]                  ilastsize_i = '0;
    logic [N-1:0][ITYPE_LEN-1:0]   itype_i = '0;
    logic [N-1:0][CAUSE_LEN-1:0]   cause_i = '0;
    logic [N-1:0][XLEN-1:0]        tval_i = '0;
    logic [N-1:0][PRIV_LEN-1:0]    priv_i = '0;
    logic [N-1:0][XLEN-1:0]        iaddr_i = '0;
    logic                          ready_i = 1'b0;
    logic                          ready_o;
    logic                          valid_o;
    logic [IRETIRE_LEN-1:0]        iretire_o;
    logic                          ilastsize_o;
    logic [ITYPE_LEN-1:0]          itype_o;
    logic [CAUSE_LEN-1:0]          cause_o;
    logic [XLEN-1:0]               tval_o;
    logic [PRIV_LEN-1:0]           priv_o;
    logic [XLEN-1:0]               iaddr_o;
    logic                          overflow_o;
    logic [15:0]                   dropped_cnt_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    te_block_serializer #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .valid_i       (valid_i),
        .iretire_i     (iretire_i),
        .ilastsize_i   (ilastsize_i),
        .itype_i       (itype_i),
        .cause_i       (cause_i),
        .tval_i        (tval_i),
        .priv_i        (priv_i),
        .iaddr_i       (iaddr_i),
        .ready_o       (ready_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .iretire_o     (iretire_o),
        .ilastsize_o   (ilastsize_o),
        .itype_o       (itype_o),
        .cause_o       (cause_o),
        .tval_o        (tval_o),
        .priv_o        (priv_o),
        .iaddr_o       (iaddr_o),
        .overflow_o    (overflow_o),
        .dropped_cnt_o (dropped_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every other field is derived from the address so field routing is checkable.
    task automatic set_lane(input int l, input logic [31:0] a);
        iretire_i[l]   = a ^ 32'h5A5A_0000;
        ilastsize_i[l] = a[2];
        itype_i[l]     = a[4:2];
        cause_i[l]     = a[8:4];
        tval_i[l]      = ~a;
        priv_i[l]      = a[3:2];
        iaddr_i[l]     = a;
    endtask

    task automatic chk_fields(input string tag, input logic [31:0] a);
        chk({tag, "_iaddr"}, iaddr_o, a);
        chk({tag, "_iretire"}, iretire_o, a ^ 32'h5A5A_0000);
        chk({tag, "_ilastsize"}, 32'(ilastsize_o), 32'(a[2]));
        chk({tag, "_itype"}, 32'(itype_o), 32'(a[4:2]));
        chk({tag, "_cause"}, 32'(cause_o), 32'(a[8:4]));
        chk({tag, "_tval"}, tval_o, ~a);
        chk({tag, "_priv"}, 32'(priv_o), 32'(a[3:2]));
    endtask

    task automatic push_pair(input logic [31:0] a0, input logic [31:0] a1);
        valid_i = 2'b11;
        set_lane(0, a0);
        set_lane(1, a1);
    endtask

    initial begin
        logic [31:0] exp_q[$];
        int sent;
        int got;

        // Reset state.
        #12;
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_ready", 32'(ready_o), 1);
        chk("rst_overflow", 32'(overflow_o), 0);
        chk("rst_dropped", 32'(dropped_cnt_o), 0);
        rst = 1'b0;

        // Full pair, drained one per cycle.
        ready_i = 1'b1;
        push_pair(32'h100, 32'h104);
        step();
        valid_i = '0;
        chk("pair_valid0", 32'(valid_o), 1);
        chk_fields("pair0", 32'h100);
        step();
        chk("pair_valid1", 32'(valid_o), 1);
        chk_fields("pair1", 32'h104);
        step();
        chk("pair_empty", 32'(valid_o), 0);

        // Gap on lane 0: lane 1 becomes the single entry.
        ready_i = 1'b0;
        valid_i = 2'b10;
        set_lane(0, 32'hDEAD);
        set_lane(1, 32'h200);
        step();
        valid_i = '0;
        chk("gap_valid", 32'(valid_o), 1);
        chk_fields("gap", 32'h200);
        ready_i = 1'b1;
        step();
        chk("gap_one_entry", 32'(valid_o), 0);

        // Fill to DEPTH with the consumer stalled, then overflow one pair.
        ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("fill_ready", 32'(ready_o), 1);
            push_pair(32'h300 + 32'(8 * k), 32'h304 + 32'(8 * k));
            step();
        end
        chk("full_ready", 32'(ready_o), 0);
        chk("full_no_ovf", 32'(overflow_o), 0);
        push_pair(32'h400, 32'h404);
        step();
        valid_i = '0;
        chk("ovf_flag", 32'(overflow_o), 1);
        chk("ovf_dropped", 32'(dropped_cnt_o), 2);
        chk("ovf_ready", 32'(ready_o), 0);
        ready_i = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk("ovf_intact_valid", 32'(valid_o), 1);
            chk("ovf_intact_addr", iaddr_o, 32'h300 + 32'(4 * j));
            step();
        end
        chk("ovf_drained", 32'(valid_o), 0);
        chk("ovf_sticky", 32'(overflow_o), 1);

        // 20 accepted pairs streaming through with pointer wrap.
        sent = 0;
        got  = 0;
        ready_i = 1'b1;
        for (int c = 0; c < 200 && got < 40; c++) begin
            if (valid_o && ready_i) begin
                if (exp_q.size() > 0) begin
                    chk("wrap_order", iaddr_o, exp_q[0]);
                    chk("wrap_tval", tval_o, ~exp_q[0]);
                    exp_q.pop_front();
                end else begin
                    chk("wrap_extra", 32'(valid_o), 0);
                end
                got++;
            end
            if (ready_o && sent < 20) begin
                push_pair(32'h1000 + 32'(8 * sent), 32'h1004 + 32'(8 * sent));
                exp_q.push_back(32'h1000 + 32'(8 * sent));
                exp_q.push_back(32'h1004 + 32'(8 * sent));
                sent++;
            end else begin
                valid_i = '0;
            end
            step();
        end
        valid_i = '0;
        chk("wrap_count", 32'(got), 40);
        chk("wrap_sent", 32'(sent), 20);
        chk("wrap_empty", 32'(valid_o), 0);
        chk("wrap_nodrop", 32'(dropped_cnt_o), 2);

        // Reset mid-stream with five blocks stored.
        ready_i = 1'b0;
        push_pair(32'h500, 32'h504);
        step();
        push_pair(32'h508, 32'h50C);
        step();
        valid_i = 2'b01;
        set_lane(0, 32'h510);
        step();
        valid_i = '0;
        chk("pre_rst_valid", 32'(valid_o), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(valid_o), 0);
        chk("mid_rst_ready", 32'(ready_o), 1);
        chk("mid_rst_overflow", 32'(overflow_o), 0);
        chk("mid_rst_dropped", 32'(dropped_cnt_o), 0);
        rst = 1'b0;
        #1;
        valid_i = 2'b01;
        set_lane(0, 32'h600);
        step();
        valid_i = '0;
        chk("post_rst_valid", 32'(valid_o), 1);
        chk_fields("post_rst", 32'h600);
        ready_i = 1'b1;
        step();
        chk("post_rst_single", 32'(valid_o), 0);

        // Saturation of the drop counter.
        ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push_pair(32'h700 + 32'(8 * k), 32'h704 + 32'(8 * k));
            step();
        end
        push_pair(32'h800, 32'h804);
        for (int k = 1; k <= 35000; k++) begin
            step();
            if (k == 1) chk("sat_first", 32'(dropped_cnt_o), 2);
            if (k == 32767) chk("sat_below", 32'(dropped_cnt_o), 32'hFFFE);
            if (k == 32768) chk("sat_hit", 32'(dropped_cnt_o), 32'hFFFF);
        end
        valid_i = '0;
        chk("sat_hold", 32'(dropped_cnt_o), 32'hFFFF);
        chk("sat_overflow", 32'(overflow_o), 1);
        chk("sat_head", iaddr_o, 32'h700);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
